hog_cell_sequencer: RTL and testbench

//  Sequences one 9-bin gradient-orientation histogram accumulator over HOG cells.
//  - Accepts a valid/ready stream of (magnitude, angle) pixel pairs.
//  - Clears the histogram, feeds PIX_PER_CELL pairs into it, then lets the last add land.
//  - Streams the 9 finished bins out serially, then returns to idle.
//  - Sits between the gradient stage and block normalisation.

---
 rtl/hog_cell_sequencer_pkg.sv | 28 ++
 rtl/hog_cell_sequencer.sv | 130 +++++++++++++
 tb/tb_hog_cell_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/hog_cell_sequencer_pkg.sv
// Shared types and constants for the HOG cell sequencer and its histogram load.
`timescale 1ns/1ps
package hog_pkg;

    localparam int unsigned MAG_W        = 14;  // ufix, En7
    localparam int unsigned ANG_W        = 14;  // sfix, En1 (half degrees)
    localparam int unsigned BIN_W        = 14;
    localparam int unsigned N_BINS       = 9;
    localparam int unsigned PIX_PER_CELL = 64;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned CELL_CNT_W   = 16;

    // Angle 0 sits outside every bin, so it doubles as the "add nothing" value.
    localparam logic [ANG_W-1:0] BUBBLE_ANGLE = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_e;

    // Counter width able to hold 0..n (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hog_cell_sequencer.sv
// Drives one 9-bin orientation histogram through a HOG cell: clear, accumulate
// CELL_PIX pixel pairs, one flush cycle for the last add, then stream the bins out.
`timescale 1ns/1ps
module hog_cell_sequencer
    import hog_pkg::*;
#(
    parameter int unsigned CELL_PIX = PIX_PER_CELL
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [MAG_W-1:0]          in_mag_i,
    input  logic [ANG_W-1:0]          in_angle_i,
    output logic                      hist_enable_o,
    output logic [MAG_W-1:0]          hist_mag_o,
    output logic [ANG_W-1:0]          hist_angle_o,
    input  logic [N_BINS*BIN_W-1:0]   hist_bins_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [BIN_W-1:0]          out_bin_o,
    output logic [IDX_W-1:0]          out_idx_o,
    output logic                      out_last_o,
    output logic                      busy_o,
    output logic [CELL_CNT_W-1:0]     cell_count_o
);

    localparam int unsigned CNT_W = cnt_width(CELL_PIX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_PIX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BINS - 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic [MAG_W-1:0]        hist_mag_q;
    logic [ANG_W-1:0]        hist_angle_q;
    logic [IDX_W-1:0]        out_idx_q;
    logic [IDX_W-1:0]        out_idx_d;
    logic [CELL_CNT_W-1:0]   cell_count_q;
    logic                    accept;
    logic                    out_hs;

    // Handshakes and incremented counters feeding the state register.
    always_comb begin
        accept    = in_valid_i && (state_q == ACCUM);
        out_hs    = out_ready_i && (state_q == OUT);
        cnt_d     = cnt_q + 1'b1;
        out_idx_d = out_idx_q + 1'b1;
    end

    // Sequencer FSM; abort outranks every other transition, and the histogram
    // operands fall back to a bubble whenever no pair is being handed over.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hist_mag_q   <= '0;
            hist_angle_q <= BUBBLE_ANGLE;
            out_idx_q    <= '0;
            cell_count_q <= '0;
        end else if (abort_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hist_mag_q   <= '0;
            hist_angle_q <= BUBBLE_ANGLE;
            out_idx_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    hist_mag_q   <= '0;
                    hist_angle_q <= BUBBLE_ANGLE;
                    out_idx_q    <= '0;
                    if (start_i) begin
                        state_q <= ACCUM;
                        cnt_q   <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        hist_mag_q   <= in_mag_i;
                        hist_angle_q <= in_angle_i;
                        cnt_q        <= cnt_d;
                        if (cnt_q == CNT_LAST) state_q <= FLUSH;
                    end else begin
                        hist_mag_q   <= '0;
                        hist_angle_q <= BUBBLE_ANGLE;
                    end
                end
                FLUSH: begin
                    // The histogram is absorbing the final pair on this edge.
                    hist_mag_q   <= '0;
                    hist_angle_q <= BUBBLE_ANGLE;
                    out_idx_q    <= '0;
                    state_q      <= OUT;
                end
                OUT: begin
                    hist_mag_q   <= '0;
                    hist_angle_q <= BUBBLE_ANGLE;
                    if (out_hs) begin
                        if (out_idx_q == IDX_LAST) begin
                            out_idx_q    <= '0;
                            cell_count_q <= cell_count_q + 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            out_idx_q <= out_idx_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decoded straight from registered state.
    always_comb begin
        in_ready_o    = (state_q == ACCUM);
        hist_enable_o = (state_q != IDLE);
        busy_o        = (state_q != IDLE);
        out_valid_o   = (state_q == OUT);
        out_last_o    = (state_q == OUT) && (out_idx_q == IDX_LAST);
        out_bin_o     = hist_bins_i[out_idx_q*BIN_W +: BIN_W];
        out_idx_o     = out_idx_q;
        hist_mag_o    = hist_mag_q;
        hist_angle_o  = hist_angle_q;
        cell_count_o  = cell_count_q;
    end

endmodule

// File: tb/tb_hog_cell_sequencer.sv
// Bench for hog_cell_sequencer driving a behavioural 9-bin histogram as its load.
`timescale 1ns/1ps
module tb_hog_cell_sequencer;
    import hog_pkg::*;

    localparam int PPC = 4;

    logic                    clk, rst_n, start, abort, in_valid, in_ready;
    logic [MAG_W-1:0]        in_mag, hist_mag;
    logic [ANG_W-1:0]        in_angle, hist_angle;
    logic                    hist_enable, out_valid, out_ready, out_last, busy;
    logic [N_BINS*BIN_W-1:0] hist_bins;
    logic [BIN_W-1:0]        out_bin;
    logic [IDX_W-1:0]        out_idx;
    logic [CELL_CNT_W-1:0]   cell_count;

    hog_cell_sequencer #(.CELL_PIX(PPC)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_mag_i(in_mag), .in_angle_i(in_angle),
        .hist_enable_o(hist_enable), .hist_mag_o(hist_mag), .hist_angle_o(hist_angle),
        .hist_bins_i(hist_bins), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_bin_o(out_bin), .out_idx_o(out_idx), .out_last_o(out_last),
        .busy_o(busy), .cell_count_o(cell_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Histogram load: bin k covers angles (20k, 20k+20] degrees, i.e. raw En1 (40k, 40k+40].
    logic [BIN_W-1:0] hbin [N_BINS];
    int hsel;
    always_comb begin
        hsel = -1;
        for (int k = 0; k < N_BINS; k++)
            if ($signed(hist_angle) > 40*k && $signed(hist_angle) <= 40*k + 40) hsel = k;
    end
    always_ff @(posedge clk) begin
        if (!hist_enable) begin
            for (int k = 0; k < N_BINS; k++) hbin[k] <= '0;
        end else if (hsel >= 0) begin
            hbin[hsel] <= hbin[hsel] + hist_mag;
        end
    end
    always_comb begin
        hist_bins = '0;
        for (int k = 0; k < N_BINS; k++) hist_bins[k*BIN_W +: BIN_W] = hbin[k];
    end

    int n_pass = 0, n_chk = 0, cells = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Reference: sum magnitudes by 20-degree sector, modulo the bin width.
    function automatic void ref_bins(input int m[PPC], input int a[PPC], output int e[N_BINS]);
        for (int k = 0; k < N_BINS; k++) e[k] = 0;
        for (int i = 0; i < PPC; i++) begin
            real deg = a[i] / 2.0;
            if (deg > 0.0 && deg <= 180.0) begin
                int b = int'($ceil(deg / 20.0)) - 1;
                e[b] = (e[b] + m[i]) % (1 << BIN_W);
            end
        end
    endfunction

    typedef struct {
        int mag [PPC];
        int ang [PPC];   // raw En1 (half degrees)
        int exp [N_BINS];
    } vec_t;

    vec_t vecs [4];

    // gap: 0 continuous, 1 pattern 1-0-0, 2 random; bp_at: index held 3 cycles (-1 none)
    task automatic do_cell(input int m[PPC], input int a[PPC], input int e[N_BINS],
                           input int gap, input int bp_at, input bit rnd_bp, input bit start_in_out);
        int i, cyc, k, stall;
        bit vld, rdy;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("accum_busy", busy, 1);
        i = 0; cyc = 0;
        while (i < PPC && cyc < 500) begin
            case (gap)
                0:       vld = 1'b1;
                1:       vld = (cyc % 3 == 0);
                default: vld = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = vld;
            if (vld) begin
                in_mag = MAG_W'(m[i]); in_angle = ANG_W'(a[i]);
            end else begin
                in_mag = MAG_W'($urandom); in_angle = ANG_W'($urandom);
            end
            chk("in_ready", in_ready, 1);
            chk("hist_en", hist_enable, 1);
            @(negedge clk);
            if (vld) i++;
            cyc++;
        end
        chk("accept_budget", i, PPC);
        in_valid = 1'b0;
        in_mag = MAG_W'($urandom); in_angle = ANG_W'($urandom);
        chk("flush_ready", in_ready, 0);
        chk("flush_ovalid", out_valid, 0);
        @(negedge clk);
        k = 0; stall = 0; cyc = 0;
        while (k < N_BINS && cyc < 500) begin
            chk("out_valid", out_valid, 1);
            chk("out_idx", out_idx, k);
            chk($sformatf("out_bin[%0d]", k), out_bin, e[k]);
            chk("out_last", out_last, (k == N_BINS - 1) ? 1 : 0);
            if (rnd_bp) rdy = ($urandom_range(0, 2) != 0);
            else if (k == bp_at && stall < 3) begin rdy = 1'b0; stall++; end
            else rdy = 1'b1;
            out_ready = rdy;
            start = start_in_out && (k == 3);
            @(negedge clk);
            start = 1'b0;
            if (rdy) k++;
            cyc++;
        end
        chk("out_budget", k, N_BINS);
        out_ready = 1'b0;
        cells++;
        chk("idle_busy", busy, 0);
        chk("idle_ovalid", out_valid, 0);
        chk("cell_count", cell_count, cells);
    endtask

    task automatic feed_two(input int m[PPC], input int a[PPC]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_mag = MAG_W'(m[i]); in_angle = ANG_W'(a[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_hist_clear(input string nm);
        int s = 0;
        for (int k = 0; k < N_BINS; k++) s += int'(hbin[k]);
        chk(nm, s, 0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int rm[PPC], ra[PPC], re[N_BINS];
        vecs[0] = '{mag: '{10, 20, 5, 7},  ang: '{30, 70, 340, 30},
                    exp: '{17, 20, 0, 0, 0, 0, 0, 0, 5}};
        vecs[1] = '{mag: '{1, 2, 4, 8},    ang: '{40, 41, 360, 0},
                    exp: '{1, 2, 0, 0, 0, 0, 0, 0, 4}};
        vecs[2] = '{mag: '{100, 200, 300, 400}, ang: '{-30, 361, 200, 1},
                    exp: '{400, 0, 0, 0, 300, 0, 0, 0, 0}};
        vecs[3] = '{mag: '{16383, 16383, 3, 0}, ang: '{100, 100, 100, 100},
                    exp: '{0, 0, 1, 0, 0, 0, 0, 0, 0}};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mag = '0; in_angle = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hist_en", hist_enable, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cell_count", cell_count, 0);
        chk("rst_hist_mag", hist_mag, 0);
        chk("rst_hist_angle", hist_angle, 0);
        chk("rst_out_idx", out_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of accumulation.
        feed_two(vecs[0].mag, vecs[0].ang);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_hist_en", hist_enable, 0);
        chk("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        chk_hist_clear("midrst_bins_clear");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, continuous valid and ready.
        for (int j = 0; j < 4; j++) begin
            do_cell(vecs[j].mag, vecs[j].ang, vecs[j].exp, 0, -1, 1'b0, 1'b0);
            @(negedge clk);
        end

        // Gapped input, then output backpressure at index 4.
        do_cell(vecs[0].mag, vecs[0].ang, vecs[0].exp, 1, -1, 1'b0, 1'b0);
        @(negedge clk);
        do_cell(vecs[0].mag, vecs[0].ang, vecs[0].exp, 0, 4, 1'b0, 1'b0);
        @(negedge clk);

        // Abort after two pairs; the following cell must be unaffected.
        feed_two(vecs[1].mag, vecs[1].ang);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_hist_en", hist_enable, 0);
        chk("abort_cell_count", cell_count, cells);
        @(negedge clk);
        chk_hist_clear("abort_bins_clear");
        do_cell(vecs[0].mag, vecs[0].ang, vecs[0].exp, 0, -1, 1'b0, 1'b0);

        // Back-to-back: start lands on the first IDLE cycle; start during OUT ignored.
        do_cell(vecs[0].mag, vecs[0].ang, vecs[0].exp, 0, -1, 1'b0, 1'b1);
        do_cell(vecs[2].mag, vecs[2].ang, vecs[2].exp, 0, -1, 1'b0, 1'b0);
        @(negedge clk);

        // Randomized cells against the reference.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < PPC; i++) begin
                rm[i] = $urandom_range(0, (1 << MAG_W) - 1);
                ra[i] = $urandom_range(0, 440) - 40;
            end
            ref_bins(rm, ra, re);
            do_cell(rm, ra, re, 2, -1, 1'b1, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
